// File: rtl/usat_addsub_pipe.sv
// Streaming unsigned add/subtract with per-transaction saturate/wrap selection,
// overflow/underflow magnitude reporting and a saturating event counter.
module usat_addsub_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int STAGES     = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in0,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic                  op,
   input  logic                  sat,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic [DATA_WIDTH-1:0] excess,
   output logic                  sig_uf,
   output logic                  sig_of,
   output logic [CNT_WIDTH-1:0]  sat_count,
   input  logic                  clr_count
);

   localparam int W = DATA_WIDTH;

   logic          adv;
   logic [W:0]    a_ext, b_ext, diff, sum;
   logic [W-1:0]  calc_out, calc_exc;
   logic          calc_uf, calc_of;

   logic [STAGES-1:0] v_q;
   logic [W-1:0]      out_q [STAGES];
   logic [W-1:0]      exc_q [STAGES];
   logic              uf_q  [STAGES];
   logic              of_q  [STAGES];
   logic [CNT_WIDTH-1:0] cnt_q;

   // One global enable: the whole pipe moves or the whole pipe holds.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_comb begin
      a_ext    = {1'b0, in0};
      b_ext    = {1'b0, in1};
      diff     = a_ext - b_ext;
      sum      = a_ext + b_ext;
      calc_out = '0;
      calc_exc = '0;
      calc_uf  = 1'b0;
      calc_of  = 1'b0;
      if (!op) begin
         calc_uf  = diff[W];
         calc_exc = diff[W] ? (in1 - in0) : '0;
         calc_out = (diff[W] && sat) ? '0 : diff[W-1:0];
      end else begin
         calc_of  = sum[W];
         calc_exc = sum[W] ? sum[W-1:0] : '0;
         calc_out = (sum[W] && sat) ? '1 : sum[W-1:0];
      end
   end

   // Payload only moves with a valid token so the output holds its last
   // result while bubbles pass through.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            out_q[i] <= '0;
            exc_q[i] <= '0;
            uf_q[i]  <= 1'b0;
            of_q[i]  <= 1'b0;
         end
      end else if (adv) begin
         v_q[0] <= in_valid;
         if (in_valid) begin
            out_q[0] <= calc_out;
            exc_q[0] <= calc_exc;
            uf_q[0]  <= calc_uf;
            of_q[0]  <= calc_of;
         end
         for (int i = 1; i < STAGES; i++) begin
            v_q[i] <= v_q[i-1];
            if (v_q[i-1]) begin
               out_q[i] <= out_q[i-1];
               exc_q[i] <= exc_q[i-1];
               uf_q[i]  <= uf_q[i-1];
               of_q[i]  <= of_q[i-1];
            end
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign out       = out_q[STAGES-1];
   assign excess    = exc_q[STAGES-1];
   assign sig_uf    = uf_q[STAGES-1];
   assign sig_of    = of_q[STAGES-1];

   always_ff @(posedge clk) begin
      if (rst || clr_count) begin
         cnt_q <= '0;
      end else if (out_valid && out_ready && (sig_uf || sig_of) && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign sat_count = cnt_q;

endmodule

// File: doc/usat_addsub_pipe.md
# usat_addsub_pipe

Pipelined, parametrised unsigned add/subtract unit with per-transaction selection of operation and saturate/wrap mode, valid/ready flow control and a saturating event counter. It generalises the combinational unsigned subtractor into a streaming arithmetic stage for datapaths that need clamped or modular arithmetic with overflow/underflow magnitude reporting. It sits between a producer and a consumer that both use valid/ready handshakes.

## Interface
- DATA_WIDTH, 8, operand/result width in bits (>= 2)
- STAGES, 2, pipeline register stages, accept-to-output latency in cycles (1..4)
- CNT_WIDTH, 16, width of the saturation-event counter

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand transaction valid
- in_ready  output  1  unit can accept a transaction this cycle
- in0, in1  input  DATA_WIDTH  unsigned operands
- op  input  1  0 = in0 - in1, 1 = in0 + in1
- sat  input  1  1 = clamp on out-of-range, 0 = wrap modulo 2^DATA_WIDTH
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result this cycle
- out  output  DATA_WIDTH  result
- excess  output  DATA_WIDTH  magnitude beyond range (0 if in range)
- sig_uf  output  1  subtraction went below 0
- sig_of  output  1  addition exceeded 2^DATA_WIDTH - 1
- sat_count  output  CNT_WIDTH  delivered results with sig_uf or sig_of set
- clr_count  input  1  synchronous clear of sat_count

## Operation
- Arithmetic done in DATA_WIDTH+1 bits on zero-extended operands, in stage 1; later stages only delay.
- op=0, in0 >= in1: out = in0 - in1, excess = 0, sig_uf = 0.
- op=0, in0 < in1: sig_uf = 1, excess = in1 - in0; out = 0 if sat, else (in0 - in1) mod 2^DATA_WIDTH.
- op=1, sum <= MAX: out = sum, excess = 0, sig_of = 0.
- op=1, sum > MAX: sig_of = 1, excess = sum - 2^DATA_WIDTH (low DATA_WIDTH bits of sum); out = MAX (all ones) if sat, else low DATA_WIDTH bits.
- sig_uf and sig_of never both 1. op and sat are sampled with the operands, per transaction.
- sat_count: increments by 1 on each output handshake (out_valid && out_ready) whose sig_uf or sig_of is 1; holds at 2^CNT_WIDTH - 1 (no wrap). clr_count forces 0 next cycle and wins over a simultaneous increment.

## Timing
- Reset: out_valid = 0, all stage valid bits = 0, out/excess/sig_uf/sig_of = 0, sat_count = 0; in_ready = 1 in the first cycle after reset release. In-flight transactions are discarded on reset; reset mid-stream produces no output.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational from out_valid/out_ready, no path from in_valid).
- Input accepted when in_valid && in_ready. When adv = 1 every stage shifts one position (bubbles included); when adv = 0 all stages hold.
- Latency: result of a transaction accepted in cycle N appears with out_valid = 1 in cycle N + STAGES if out_ready stays high.
- Throughput: one transaction per cycle with out_ready held high.
- out, excess, sig_uf, sig_of are stable while out_valid = 1 and out_ready = 0; they hold last values when out_valid = 0 (no requirement on their value then, except after reset).
- Order preserved; no drop or duplication under any in_valid/out_ready pattern.

## Test plan
- DATA_WIDTH=8, STAGES=2: op=0, sat=1, in0=200, in1=50 accepted cycle 0 -> cycle 2 out=150, excess=0, sig_uf=0, sig_of=0.
- op=0, in0=10, in1=30: sat=1 -> out=0, excess=20, sig_uf=1; sat=0 -> out=236, excess=20, sig_uf=1; sat_count goes 0 -> 1 -> 2.
- op=1, in0=200, in1=100: sat=1 -> out=255, excess=44, sig_of=1; sat=0 -> out=44, excess=44, sig_of=1; op=1, 100+155 -> out=255, sig_of=0.
- Back-pressure: 4 back-to-back inputs, out_ready low cycles 3..6 -> in_ready low while out_valid && !out_ready, held result stable, all 4 results delivered in order, none lost.
- CNT_WIDTH=2: 5 overflowing results delivered -> sat_count 1,2,3,3,3; clr_count asserted in same cycle as a 6th overflow handshake -> sat_count = 0.
- rst asserted for 1 cycle with 2 transactions in flight -> next cycle out_valid=0, sat_count=0, in_ready=1; no stale results ever emerge.
